// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between several byte producers.
// One byte per grant, held until the frame completes or tx_busy never rises.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int BITS_PER_WORD  = 8,
    parameter int ACCEPT_TIMEOUT = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*BITS_PER_WORD-1:0]   req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [BITS_PER_WORD-1:0]           tx_data,
    output logic                               tx_data_valid,
    input  logic                               tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id,
    output logic                               done_pulse,
    output logic                               timeout_pulse
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(ACCEPT_TIMEOUT);
    localparam int W  = BITS_PER_WORD;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win;
    logic            hit;
    logic [CW-1:0]   cnt;
    logic            grant;
    logic            fin_done;
    logic            fin_to;

    // Winner: first valid requester scanning from ptr upward, wrapping.
    always_comb begin
        win = '0;
        hit = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(ptr) + k) % NUM_REQ]) begin
                win = IW'((int'(ptr) + k) % NUM_REQ);
                hit = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and handshake strobes; no grant while reset is held.
    always_comb begin
        state_n       = state;
        req_ready     = '0;
        tx_data_valid = 1'b0;
        grant         = 1'b0;
        fin_done      = 1'b0;
        fin_to        = 1'b0;
        unique case (state)
            IDLE: begin
                if (rst_n && hit && !tx_busy) begin
                    grant          = 1'b1;
                    req_ready[win] = 1'b1;
                    state_n        = ISSUE;
                end
            end
            ISSUE: begin
                tx_data_valid = 1'b1;
                state_n       = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_n = WAIT_DONE;
                end else if (cnt == CW'(ACCEPT_TIMEOUT - 2)) begin
                    fin_to  = 1'b1;
                    state_n = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    fin_done = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Byte capture, accept-timeout counter, pointer advance and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data       <= '0;
            grant_id      <= '0;
            ptr           <= '0;
            cnt           <= '0;
            done_pulse    <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            done_pulse    <= fin_done;
            timeout_pulse <= fin_to;
            if (grant) begin
                tx_data  <= req_data[win*W +: W];
                grant_id <= win;
            end
            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT_BUSY) begin
                cnt <= cnt + 1'b1;
            end
            if (fin_done || fin_to) begin
                if (grant_id == IW'(NUM_REQ - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= grant_id + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed grant orders and latencies.
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int A = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   tx_data;
    logic           tx_data_valid;
    logic           tx_busy = 1'b0;
    logic [1:0]     grant_id;
    logic           done_pulse;
    logic           timeout_pulse;

    uart_tx_arbiter #(
        .NUM_REQ(N),
        .BITS_PER_WORD(W),
        .ACCEPT_TIMEOUT(A)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .tx_data(tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_busy(tx_busy),
        .grant_id(grant_id),
        .done_pulse(done_pulse),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Producers: requester i keeps req_valid high until it has sent quota[i] bytes.
    int quota[N] = '{default: 0};
    int sent[N]  = '{default: 0};
    logic [N-1:0] hs = '0;

    always_comb begin
        req_valid = '0;
        for (int i = 0; i < N; i++) req_valid[i] = sent[i] < quota[i];
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) sent[i]++;
    end

    // Transmitter: busy from 2 cycles after valid, for 10 cycles (mode 1),
    // never busy (mode 0), or forced busy from outside.
    int   tv = -1000;
    int   mode = 1;
    logic force_busy = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) tv = -1000;
        else if (tx_data_valid) tv = cyc;
    end

    always @(posedge clk) begin
        #2;
        tx_busy = force_busy || (mode == 1 && cyc >= tv + 2 && cyc < tv + 12);
    end

    // Event logs taken from DUT outputs.
    int         g_id[$];
    int         g_cyc[$];
    int         g_vec[$];
    int         v_cyc[$];
    logic [7:0] v_dat[$];
    int         d_cyc[$];
    int         t_cyc[$];

    task automatic clr();
        g_id.delete(); g_cyc.delete(); g_vec.delete();
        v_cyc.delete(); v_dat.delete(); d_cyc.delete(); t_cyc.delete();
    endtask

    // Model: one byte in flight; it ends with done the cycle after busy falls,
    // or with timeout A cycles after the valid pulse when busy never rose.
    bit         m_busy = 0;
    bit         m_seen = 0;
    bit         m_end_done = 0;
    int         m_ptr = 0;
    int         m_gid = 0;
    int         m_vis = 0;
    int         m_g = 0;
    int         m_end = -1;
    int         w;
    logic [7:0] m_data = '0;
    logic [N-1:0] e_ready;
    bit         e_done;
    bit         e_to;

    always @(negedge clk) begin
        hs = req_ready;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                g_id.push_back(i);
                g_cyc.push_back(cyc);
                g_vec.push_back(int'(req_ready));
            end
        end
        if (tx_data_valid) begin
            v_cyc.push_back(cyc);
            v_dat.push_back(tx_data);
        end
        if (done_pulse) d_cyc.push_back(cyc);
        if (timeout_pulse) t_cyc.push_back(cyc);

        if (!rst_n) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_valid", tx_data_valid, 0);
            chk("rst_data", tx_data, 0);
            chk("rst_gid", grant_id, 0);
            chk("rst_done", done_pulse, 0);
            chk("rst_to", timeout_pulse, 0);
            m_busy = 0; m_ptr = 0; m_gid = 0; m_vis = 0; m_end = -1;
        end else begin
            e_done = 0;
            e_to = 0;
            if (m_busy && cyc == m_end) begin
                e_done = m_end_done;
                e_to = !m_end_done;
                m_busy = 0;
                m_ptr = (m_gid + 1) % N;
            end
            e_ready = '0;
            if (!m_busy && req_valid != 0 && !tx_busy) begin
                for (int k = 0; k < N; k++) begin
                    w = (m_ptr + k) % N;
                    if (req_valid[w]) break;
                end
                e_ready[w] = 1'b1;
                m_busy = 1; m_seen = 0; m_end = -1;
                m_g = cyc; m_gid = w;
                m_data = req_data[w*W +: W];
            end
            chk("ready", req_ready, e_ready);
            chk("valid", tx_data_valid, m_busy && cyc == m_g + 1);
            chk("done", done_pulse, e_done);
            chk("timeout", timeout_pulse, e_to);
            chk("grant_id", grant_id, m_vis);
            if (m_busy && cyc > m_g) chk("tx_data", tx_data, m_data);
            m_vis = m_gid;
            if (m_busy && m_end < 0 && cyc >= m_g + 2) begin
                if (!m_seen) begin
                    if (tx_busy) m_seen = 1;
                    else if (cyc == m_g + A) begin
                        m_end = cyc + 1;
                        m_end_done = 0;
                    end
                end else if (!tx_busy) begin
                    m_end = cyc + 1;
                    m_end_done = 1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ends(input int n, input int lim, input string nm);
        int k = 0;
        while (d_cyc.size() + t_cyc.size() < n && k < lim) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk({nm, "_bound"}, d_cyc.size() + t_cyc.size() >= n, 1);
    endtask

    task automatic wait_quiet(input int lim, input string nm);
        int k = 0;
        while ((req_valid != 0 || m_busy) && k < lim) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk({nm, "_quiet"}, req_valid == 0 && !m_busy, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        clr();
        rst_n = 1'b1;
    endtask

    initial begin
        int rel;
        int k;
        tick(3);
        rst_n = 1'b1;

        // Single requester 2.
        clr();
        req_data = {8'h33, 8'hA5, 8'h11, 8'h00};
        quota[2] = sent[2] + 1;
        wait_ends(1, 100, "t1");
        wait_quiet(100, "t1");
        chk("t1_ngrant", g_id.size(), 1);
        chk("t1_vec", g_vec[0], 4'b0100);
        chk("t1_vlat", v_cyc[0] - g_cyc[0], 1);
        chk("t1_nvalid", v_cyc.size(), 1);
        chk("t1_data", v_dat[0], 8'hA5);
        chk("t1_ndone", d_cyc.size(), 1);
        chk("t1_dlat", d_cyc[0] - g_cyc[0], 14);
        chk("t1_nto", t_cyc.size(), 0);
        chk("t1_gid", grant_id, 2);

        // All four requesting continuously.
        do_reset();
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < N; i++) quota[i] = sent[i] + 2;
        wait_ends(5, 400, "t2");
        chk("t2_g0", g_id[0], 0);
        chk("t2_g1", g_id[1], 1);
        chk("t2_g2", g_id[2], 2);
        chk("t2_g3", g_id[3], 3);
        chk("t2_g4", g_id[4], 0);
        chk("t2_ndone", d_cyc.size(), 5);
        chk("t2_vec3", g_vec[3], 4'b1000);
        chk("t2_dat3", v_dat[3], 8'h13);
        wait_quiet(400, "t2");
        chk("t2_total", g_id.size(), 8);

        // Wrap after granting 3.
        do_reset();
        quota[3] = sent[3] + 1;
        wait_ends(1, 100, "t3a");
        wait_quiet(100, "t3a");
        quota[0] = sent[0] + 1;
        quota[3] = sent[3] + 1;
        wait_ends(3, 200, "t3b");
        wait_quiet(100, "t3b");
        chk("t3_g0", g_id[0], 3);
        chk("t3_g1", g_id[1], 0);
        chk("t3_g2", g_id[2], 3);

        // Transmitter never goes busy.
        do_reset();
        mode = 0;
        quota[1] = sent[1] + 1;
        quota[2] = sent[2] + 1;
        wait_ends(2, 200, "t4");
        wait_quiet(100, "t4");
        chk("t4_nto", t_cyc.size(), 2);
        chk("t4_ndone", d_cyc.size(), 0);
        chk("t4_tlat0", t_cyc[0] - v_cyc[0], 16);
        chk("t4_tlat1", t_cyc[1] - v_cyc[1], 16);
        chk("t4_g0", g_id[0], 1);
        chk("t4_g1", g_id[1], 2);
        chk("t4_regrant", g_cyc[1], t_cyc[0]);
        mode = 1;

        // Foreign busy blocks granting.
        do_reset();
        force_busy = 1'b1;
        tick(2);
        quota[1] = sent[1] + 1;
        tick(20);
        chk("t5_blocked", g_id.size(), 0);
        force_busy = 1'b0;
        rel = cyc;
        wait_ends(1, 100, "t5");
        wait_quiet(100, "t5");
        chk("t5_id", g_id[0], 1);
        chk("t5_when", g_cyc[0], rel);

        // Reset during WAIT_DONE.
        do_reset();
        quota[2] = sent[2] + 1;
        k = 0;
        while (v_cyc.size() == 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        chk("t6_issue_bound", v_cyc.size(), 1);
        tick(5);
        rst_n = 1'b0;
        quota[0] = sent[0] + 1;
        #1;
        chk("t6_ready0", req_ready, 0);
        chk("t6_valid0", tx_data_valid, 0);
        chk("t6_data0", tx_data, 0);
        chk("t6_gid0", grant_id, 0);
        tick(2);
        clr();
        rst_n = 1'b1;
        wait_ends(1, 100, "t6");
        wait_quiet(100, "t6");
        chk("t6_id", g_id[0], 0);
        chk("t6_ndone", d_cyc.size(), 1);
        chk("t6_dlat", d_cyc[0] - g_cyc[0], 14);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish by 1000000");
        $fatal(1);
    end

endmodule
